// File: rtl/iter_mdu_if.sv
// rtl/iter_mdu_if.sv - request/response bundle for iter_mdu (flush member only with MDU_FLUSH_EN)
interface iter_mdu_if #(
   parameter int XLEN = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [2:0]      op;
   logic [XLEN-1:0] src1;
   logic [XLEN-1:0] src2;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] result;
   logic            busy;
`ifdef MDU_FLUSH_EN
   logic            flush;

   modport master (
      output in_valid, op, src1, src2, out_ready, flush,
      input  in_ready, out_valid, result, busy
   );
   modport slave (
      input  in_valid, op, src1, src2, out_ready, flush,
      output in_ready, out_valid, result, busy
   );
`else
   modport master (
      output in_valid, op, src1, src2, out_ready,
      input  in_ready, out_valid, result, busy
   );
   modport slave (
      input  in_valid, op, src1, src2, out_ready,
      output in_ready, out_valid, result, busy
   );
`endif
endinterface

// File: rtl/iter_mdu.sv
// rtl/iter_mdu.sv - radix-2 iterative RV32M multiply/divide unit; MDU_FLUSH_EN adds a flush input
module iter_mdu #(
   parameter int XLEN = 32
) (
   input  logic       clk,
   input  logic       rst,
   iter_mdu_if.slave  bus
);
   localparam int CW = $clog2(XLEN);
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [2:0] {
      IDLE,
      PREP,
      CALC,
      FIX,
      DONE
   } state_t;

   state_t state;
   state_t state_nx;

   logic [2:0]      op_q;
   logic [XLEN-1:0] a_q;
   logic [XLEN-1:0] b_q;
   logic [XLEN-1:0] opnd;
   logic [XLEN-1:0] acc_hi;
   logic [XLEN-1:0] acc_lo;
   logic [CW-1:0]   cnt;
   logic            neg_a;
   logic            neg_b;
   logic            div_zero;
   logic            div_ovf;
   logic [XLEN-1:0] result_q;

   logic            flush_i;
   logic            accept;
   logic            is_div;
   logic            a_signed;
   logic            b_signed;
   logic            s1;
   logic            s2;
   logic [XLEN-1:0] abs_a;
   logic [XLEN-1:0] abs_b;
   logic [XLEN:0]   mul_sum;
   logic [XLEN:0]   div_shift;
   logic [XLEN:0]   div_diff;
   logic [2*XLEN-1:0] prod;
   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0] quo_fix;
   logic [XLEN-1:0] rem_fix;
   logic [XLEN-1:0] res_sel;

`ifdef MDU_FLUSH_EN
   assign flush_i = bus.flush;
`else
   assign flush_i = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state logic; flush overrides every non-idle state
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (accept) state_nx = PREP;
         PREP: state_nx = CALC;
         CALC: if (cnt == '0) state_nx = FIX;
         FIX:  state_nx = DONE;
         DONE: if (bus.out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
      if (flush_i && state != IDLE) begin
         state_nx = IDLE;
      end
   end

   // Outputs
   always_comb begin
      bus.in_ready  = (state == IDLE) && !flush_i;
      bus.busy      = (state != IDLE);
      bus.out_valid = (state == DONE);
      bus.result    = result_q;
   end

   assign accept = (state == IDLE) && bus.in_valid && bus.in_ready;

   // Operand decode
   always_comb begin
      is_div   = op_q[2];
      a_signed = (op_q == 3'b001) || (op_q == 3'b010) || (op_q == 3'b100) || (op_q == 3'b110);
      b_signed = (op_q == 3'b001) || (op_q == 3'b100) || (op_q == 3'b110);
      s1       = a_signed && a_q[XLEN-1];
      s2       = b_signed && b_q[XLEN-1];
      abs_a    = s1 ? -a_q : a_q;
      abs_b    = s2 ? -b_q : b_q;
   end

   // One iteration step: shift-add for multiply, restoring subtract for divide
   always_comb begin
      mul_sum   = {1'b0, acc_hi} + ({1'b0, opnd} & {(XLEN+1){acc_lo[0]}});
      div_shift = {acc_hi, acc_lo[XLEN-1]};
      div_diff  = div_shift - {1'b0, opnd};
   end

   // Sign correction and output selection
   always_comb begin
      prod     = {acc_hi, acc_lo};
      prod_fix = (neg_a ^ neg_b) ? -prod : prod;
      quo_fix  = (neg_a ^ neg_b) ? -acc_lo : acc_lo;
      rem_fix  = neg_a ? -acc_hi : acc_hi;
      res_sel  = '0;
      case (op_q)
         3'b000: res_sel = prod_fix[XLEN-1:0];
         3'b001,
         3'b010,
         3'b011: res_sel = prod_fix[2*XLEN-1:XLEN];
         3'b100,
         3'b101: begin
            if (div_zero)     res_sel = '1;
            else if (div_ovf) res_sel = MIN_NEG;
            else              res_sel = quo_fix;
         end
         default: begin
            if (div_zero)     res_sel = a_q;
            else if (div_ovf) res_sel = '0;
            else              res_sel = rem_fix;
         end
      endcase
   end

   // Datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         opnd     <= '0;
         acc_hi   <= '0;
         acc_lo   <= '0;
         cnt      <= '0;
         neg_a    <= 1'b0;
         neg_b    <= 1'b0;
         div_zero <= 1'b0;
         div_ovf  <= 1'b0;
         result_q <= '0;
      end else begin
         if (accept) begin
            op_q <= bus.op;
            a_q  <= bus.src1;
            b_q  <= bus.src2;
         end
         if (state == PREP) begin
            neg_a    <= s1;
            neg_b    <= s2;
            acc_hi   <= '0;
            // Divide iterates the dividend through acc_lo; multiply iterates the multiplier
            acc_lo   <= is_div ? abs_a : abs_b;
            opnd     <= is_div ? abs_b : abs_a;
            div_zero <= (b_q == '0);
            div_ovf  <= ((op_q == 3'b100) || (op_q == 3'b110)) && (a_q == MIN_NEG) && (b_q == '1);
            cnt      <= CW'(XLEN - 1);
         end
         if (state == CALC && !flush_i) begin
            if (cnt != '0) begin
               cnt <= cnt - CW'(1);
            end
            if (is_div) begin
               if (!div_diff[XLEN]) begin
                  acc_hi <= div_diff[XLEN-1:0];
                  acc_lo <= {acc_lo[XLEN-2:0], 1'b1};
               end else begin
                  acc_hi <= div_shift[XLEN-1:0];
                  acc_lo <= {acc_lo[XLEN-2:0], 1'b0};
               end
            end else begin
               acc_hi <= mul_sum[XLEN:1];
               acc_lo <= {mul_sum[0], acc_lo[XLEN-1:1]};
            end
         end
         if (state == FIX && !flush_i) begin
            result_q <= res_sel;
         end
      end
   end
endmodule
